// File: rtl/enigma_pkg.sv
// Shared types and helpers for the Enigma rotor datapath.
//   ALPHA_DEFAULT / W_DEFAULT : default alphabet size and letter width
//   letter_t                  : letter encoding 1..ALPHA, 0 = invalid
//   sum_t                     : width used for modular sums
//   rotor_state_e             : rotor slot state (IDLE, LOAD, READY)
//   mod_add(a, b, m)          : (a + b) mod m with a single conditional
//                               subtract; valid only when a + b < 2*m
package enigma_pkg;

  localparam int ALPHA_DEFAULT = 26;
  localparam int W_DEFAULT     = $clog2(ALPHA_DEFAULT + 1);

  typedef logic [W_DEFAULT-1:0] letter_t;

  // Wide enough for a + b with any alphabet up to 127 letters.
  typedef logic [7:0] sum_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    READY = 2'd2
  } rotor_state_e;

  function automatic sum_t mod_add(input sum_t a, input sum_t b, input sum_t m);
    sum_t s;
    s = a + b;
    if (s >= m) s = s - m;
    return s;
  endfunction

endpackage

// File: rtl/enigma_rotor_table.sv
// rotor_table: forward and inverse wiring tables for one rotor slot.
// Entries are indexed 1..ALPHA; an entry of 0 means "not loaded".
// Optional macro ROTOR_PERM_CHECK_EN adds a "used" vector over load values
// and flags duplicate values or re-written indexes on 'dup'.
//   clk, rst_n          : clock, asynchronous active-low reset
//   clr                 : synchronous clear of both tables (and used vector)
//   we, widx, wval      : write fwd[widx] = wval and inv[wval] = widx
//   fwd_addr / fwd_data : combinational read of fwd (0 for out-of-range)
//   inv_addr / inv_data : combinational read of inv (0 for out-of-range)
//   dup                 : write would break the permutation (check build only)
module rotor_table
  import enigma_pkg::*;
#(
  parameter int ALPHA = ALPHA_DEFAULT,
  parameter int W     = $clog2(ALPHA + 1)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         we,
  input  logic [W-1:0] widx,
  input  logic [W-1:0] wval,
  input  logic [W-1:0] fwd_addr,
  output logic [W-1:0] fwd_data,
  input  logic [W-1:0] inv_addr,
  output logic [W-1:0] inv_data,
  output logic         dup
);

  localparam logic [W-1:0] ALPHA_L = W'(ALPHA);

  logic [W-1:0] fwd_mem [1:ALPHA];
  logic [W-1:0] inv_mem [1:ALPHA];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 1; i <= ALPHA; i++) begin
        fwd_mem[i] <= '0;
        inv_mem[i] <= '0;
      end
    end else if (clr) begin
      for (int i = 1; i <= ALPHA; i++) begin
        fwd_mem[i] <= '0;
        inv_mem[i] <= '0;
      end
    end else if (we) begin
      fwd_mem[widx] <= wval;
      inv_mem[wval] <= widx;
    end
  end

  always_comb begin
    fwd_data = '0;
    inv_data = '0;
    if (fwd_addr != '0 && fwd_addr <= ALPHA_L) fwd_data = fwd_mem[fwd_addr];
    if (inv_addr != '0 && inv_addr <= ALPHA_L) inv_data = inv_mem[inv_addr];
  end

`ifdef ROTOR_PERM_CHECK_EN
  logic [ALPHA:1] used;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      used <= '0;
    else if (clr)    used <= '0;
    else if (we)     used[wval] <= 1'b1;
  end

  // A value seen before, or an index that already holds an entry.
  always_comb begin
    dup = 1'b0;
    if (wval != '0 && wval <= ALPHA_L && widx != '0 && widx <= ALPHA_L)
      dup = used[wval] | (fwd_mem[widx] != '0);
  end
`else
  assign dup = 1'b0;
`endif

endmodule

// File: rtl/enigma_rotor_stage.sv
// enigma_rotor_stage: one programmable rotor slot. Holds a loadable wiring
// (forward table plus inverse built during the load), the rotor position,
// ring setting and notch, and translates letters in either direction with
// a one-cycle registered result. Optional macro ROTOR_PERM_CHECK_EN rejects
// load entries that would make the wiring non-bijective.
//   load_start/valid/idx/val, load_ready : wiring load port
//   cfg_we, cfg_pos/ring/notch           : position/ring/notch setup
//   step, carry_out, pos                 : stepping and notch carry
//   in_valid/dir/letter                  : translate request
//   out_valid/letter                     : registered result (0 on error)
//   ready, err                           : table complete, sticky error
//   dbg_state                            : current FSM state
// Handshake: a load entry transfers on a cycle with load_valid && load_ready;
// load_ready depends only on state, never on load_valid.
module enigma_rotor_stage
  import enigma_pkg::*;
#(
  parameter int ALPHA = ALPHA_DEFAULT,
  parameter int W     = $clog2(ALPHA + 1)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load_start,
  input  logic         load_valid,
  input  logic [W-1:0] load_idx,
  input  logic [W-1:0] load_val,
  output logic         load_ready,
  input  logic         cfg_we,
  input  logic [W-1:0] cfg_pos,
  input  logic [W-1:0] cfg_ring,
  input  logic [W-1:0] cfg_notch,
  input  logic         step,
  output logic         carry_out,
  input  logic         in_valid,
  input  logic         in_dir,
  input  logic [W-1:0] in_letter,
  output logic         out_valid,
  output logic [W-1:0] out_letter,
  output logic         ready,
  output logic         err,
  output logic [W-1:0] pos,
  output rotor_state_e dbg_state
);

  localparam logic [W-1:0] ALPHA_L  = W'(ALPHA);
  localparam logic [W-1:0] ALPHA_M1 = W'(ALPHA - 1);
  localparam logic [W-1:0] ONE_L    = W'(1);
  localparam sum_t         A_S      = sum_t'(ALPHA);
  localparam sum_t         ONE_S    = sum_t'(1);

  rotor_state_e state, state_d;
  logic [W-1:0] cnt;
  logic [W-1:0] pos_q, ring_q, notch_q, off_q;
  logic [W-1:0] pos_d, ring_d, notch_d, off_d;
  logic         carry_d, carry_q;
  logic         err_q, out_valid_q;
  logic [W-1:0] out_letter_q;

  // Load write qualification; load_start always drops a same-cycle write.
  logic         wr_req, idx_ok, val_ok, dup, wr_en, wr_bad;
  assign wr_req = load_valid && load_ready && !load_start;
  assign idx_ok = (load_idx != '0) && (load_idx <= ALPHA_L);
  assign val_ok = (load_val != '0) && (load_val <= ALPHA_L);
  assign wr_en  = wr_req && idx_ok && val_ok && !dup;
  assign wr_bad = wr_req && !(idx_ok && val_ok && !dup);

  // Translation datapath, all evaluated at the issue cycle.
  logic         in_ok, tr_err;
  sum_t         m_s, o_s;
  logic [W-1:0] rd_addr, fwd_data, inv_data, w;
  assign in_ok   = (in_letter != '0) && (in_letter <= ALPHA_L);
  assign m_s     = mod_add(sum_t'(in_letter) - ONE_S, sum_t'(off_q), A_S);
  assign rd_addr = W'(m_s + ONE_S);
  assign w       = in_dir ? inv_data : fwd_data;
  assign o_s     = mod_add(sum_t'(w) - ONE_S, A_S - sum_t'(off_q), A_S) + ONE_S;
  assign tr_err  = in_valid && (!in_ok || state != READY || w == '0);

  rotor_table #(.ALPHA(ALPHA), .W(W)) u_table (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr      (load_start),
    .we       (wr_en),
    .widx     (load_idx),
    .wval     (load_val),
    .fwd_addr (rd_addr),
    .fwd_data (fwd_data),
    .inv_addr (rd_addr),
    .inv_data (inv_data),
    .dup      (dup)
  );

  // FSM: state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_d;
  end

  // FSM: next state
  always_comb begin
    state_d = state;
    if (load_start)
      state_d = LOAD;
    else if (state == LOAD && wr_en && cnt == ALPHA_M1)
      state_d = READY;
  end

  // FSM: outputs
  always_comb begin
    load_ready = (state == LOAD);
    ready      = (state == READY);
    dbg_state  = state;
  end

  // Position/ring/notch next values. cfg_we wins over step and never carries.
  always_comb begin
    pos_d   = pos_q;
    ring_d  = ring_q;
    notch_d = notch_q;
    if (cfg_we) begin
      pos_d   = cfg_pos;
      ring_d  = cfg_ring;
      notch_d = cfg_notch;
    end else if (step) begin
      pos_d = (pos_q == ALPHA_L) ? ONE_L : pos_q + ONE_L;
    end
    carry_d = step && !cfg_we && (pos_q == notch_q);
    // off = (pos - ring) mod ALPHA, written as pos + (ALPHA - ring).
    off_d   = W'(mod_add(sum_t'(pos_d), A_S - sum_t'(ring_d), A_S));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt          <= '0;
      pos_q        <= ONE_L;
      ring_q       <= ONE_L;
      notch_q      <= ALPHA_L;
      off_q        <= '0;
      carry_q      <= 1'b0;
      err_q        <= 1'b0;
      out_valid_q  <= 1'b0;
      out_letter_q <= '0;
    end else begin
      if (load_start) cnt <= '0;
      else if (wr_en) cnt <= cnt + ONE_L;
      pos_q        <= pos_d;
      ring_q       <= ring_d;
      notch_q      <= notch_d;
      off_q        <= off_d;
      carry_q      <= carry_d;
      err_q        <= load_start ? 1'b0 : (err_q | wr_bad | tr_err);
      out_valid_q  <= in_valid;
      out_letter_q <= (in_valid && !tr_err) ? W'(o_s) : '0;
    end
  end

  assign carry_out  = carry_q;
  assign err        = err_q;
  assign out_valid  = out_valid_q;
  assign out_letter = out_letter_q;
  assign pos        = pos_q;

endmodule

// File: tb/tb_enigma_rotor_stage.sv
// Directed bench for enigma_rotor_stage: loads Enigma rotor II, checks
// translations from a vector table, then stepping/notch, load error and
// restart cases, the duplicate-value behaviour and reset during a load.
module tb_enigma_rotor_stage;
  import enigma_pkg::*;

  localparam int ALPHA = 26;
  localparam int W     = 5;

  // clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n;

  logic         load_start, load_valid, load_ready;
  logic [W-1:0] load_idx, load_val;
  logic         cfg_we;
  logic [W-1:0] cfg_pos, cfg_ring, cfg_notch;
  logic         step, carry_out;
  logic         in_valid, in_dir;
  logic [W-1:0] in_letter;
  logic         out_valid;
  logic [W-1:0] out_letter;
  logic         ready, err;
  logic [W-1:0] pos;
  rotor_state_e dbg_state;

  enigma_rotor_stage #(.ALPHA(ALPHA), .W(W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_start (load_start),
    .load_valid (load_valid),
    .load_idx   (load_idx),
    .load_val   (load_val),
    .load_ready (load_ready),
    .cfg_we     (cfg_we),
    .cfg_pos    (cfg_pos),
    .cfg_ring   (cfg_ring),
    .cfg_notch  (cfg_notch),
    .step       (step),
    .carry_out  (carry_out),
    .in_valid   (in_valid),
    .in_dir     (in_dir),
    .in_letter  (in_letter),
    .out_valid  (out_valid),
    .out_letter (out_letter),
    .ready      (ready),
    .err        (err),
    .pos        (pos),
    .dbg_state  (dbg_state)
  );

  // scoreboard counters
  int checks   = 0;
  int failures = 0;

  // Rotor II: AJDKSIRUXBLHWTMCQGZNPYFVOE
  int wiring [26] = '{1, 10, 4, 11, 19, 9, 18, 21, 24, 2, 12, 8, 23,
                      20, 13, 3, 17, 7, 26, 14, 16, 25, 6, 22, 15, 5};

  typedef struct {
    logic dir;
    int   letter;
    int   rpos;
    int   ring;
    int   exp;
    int   exp_err;
  } vec_t;

  vec_t vecs [12];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  // Inputs change 1 time unit after the rising edge; outputs are sampled there too.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write_entry(input int idx, input int val);
    load_valid = 1'b1;
    load_idx   = W'(idx);
    load_val   = W'(val);
    tick();
    load_valid = 1'b0;
  endtask

  task automatic start_load();
    load_start = 1'b1;
    tick();
    load_start = 1'b0;
  endtask

  task automatic load_rotor();
    start_load();
    for (int i = 1; i <= ALPHA; i++) write_entry(i, wiring[i-1]);
  endtask

  task automatic set_cfg(input int p, input int r, input int n);
    cfg_we    = 1'b1;
    cfg_pos   = W'(p);
    cfg_ring  = W'(r);
    cfg_notch = W'(n);
    tick();
    cfg_we = 1'b0;
  endtask

  task automatic translate(input string name, input logic dir, input int letter, input int exp);
    in_valid  = 1'b1;
    in_dir    = dir;
    in_letter = W'(letter);
    tick();
    in_valid = 1'b0;
    check({name, "_valid"}, 32'(out_valid), 32'd1);
    check(name, 32'(out_letter), 32'(exp));
  endtask

  initial begin
    // dir, letter, pos, ring, expected letter, expected sticky err
    vecs[0]  = '{1'b0,  2,  1,  1, 10, 0};
    vecs[1]  = '{1'b1, 10,  1,  1,  2, 0};
    vecs[2]  = '{1'b0,  1,  2,  1,  9, 0};
    vecs[3]  = '{1'b1,  9,  2,  1,  1, 0};
    vecs[4]  = '{1'b0, 26,  1,  1,  5, 0};
    vecs[5]  = '{1'b1,  5,  1,  1, 26, 0};
    vecs[6]  = '{1'b0,  1, 26,  1,  6, 0};
    vecs[7]  = '{1'b0,  3,  1,  2, 11, 0};
    vecs[8]  = '{1'b1, 11,  1,  2,  3, 0};
    vecs[9]  = '{1'b1,  1,  3,  1, 14, 0};
    vecs[10] = '{1'b0, 27,  1,  1,  0, 1};
    vecs[11] = '{1'b1,  0,  1,  1,  0, 1};

    rst_n = 1'b0;
    load_start = 1'b0; load_valid = 1'b0; load_idx = '0; load_val = '0;
    cfg_we = 1'b0; cfg_pos = '0; cfg_ring = '0; cfg_notch = '0;
    step = 1'b0; in_valid = 1'b0; in_dir = 1'b0; in_letter = '0;
    tick();
    tick();

    // reset state
    check("rst_state", 32'(dbg_state), 32'(IDLE));
    check("rst_pos", 32'(pos), 32'd1);
    check("rst_ready", 32'(ready), 32'd0);
    check("rst_load_ready", 32'(load_ready), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_carry", 32'(carry_out), 32'd0);
    rst_n = 1'b1;
    tick();

    // translate before any load
    translate("preload_tr", 1'b0, 2, 0);
    check("preload_err", 32'(err), 32'd1);

    // load: bad index, restart with a same-cycle write that must be dropped
    start_load();
    check("load_err_clr", 32'(err), 32'd0);
    check("load_ready_hi", 32'(load_ready), 32'd1);
    write_entry(27, 1);
    check("bad_idx_err", 32'(err), 32'd1);
    load_start = 1'b1;
    write_entry(1, wiring[0]);
    load_start = 1'b0;
    check("restart_err_clr", 32'(err), 32'd0);
    for (int i = 2; i <= ALPHA; i++) write_entry(i, wiring[i-1]);
    check("dropped_write_not_ready", 32'(ready), 32'd0);
    write_entry(1, wiring[0]);
    check("load_done_ready", 32'(ready), 32'd1);
    check("load_done_lr", 32'(load_ready), 32'd0);

    // translation vectors
    for (int i = 0; i < 12; i++) begin
      set_cfg(vecs[i].rpos, vecs[i].ring, ALPHA);
      translate($sformatf("vec%0d", i), vecs[i].dir, vecs[i].letter, vecs[i].exp);
      check($sformatf("vec%0d_err", i), 32'(err), 32'(vecs[i].exp_err));
    end

    // back-to-back requests, step in the same cycle as the first
    set_cfg(1, 1, ALPHA);
    in_valid = 1'b1; in_dir = 1'b0; in_letter = W'(2); step = 1'b1;
    tick();
    step = 1'b0;
    in_letter = W'(1);
    check("prestep_tr", 32'(out_letter), 32'd10);
    check("prestep_pos", 32'(pos), 32'd2);
    tick();
    in_valid = 1'b0;
    check("poststep_valid", 32'(out_valid), 32'd1);
    check("poststep_tr", 32'(out_letter), 32'd9);

    // notch carry
    set_cfg(5, 1, 5);
    check("notch_pre_carry", 32'(carry_out), 32'd0);
    step = 1'b1;
    tick();
    step = 1'b0;
    check("notch_pos", 32'(pos), 32'd6);
    check("notch_carry", 32'(carry_out), 32'd1);
    tick();
    check("notch_carry_once", 32'(carry_out), 32'd0);

    // cfg_we beats step, no carry
    set_cfg(5, 1, 5);
    cfg_we = 1'b1; cfg_pos = W'(5); step = 1'b1;
    tick();
    cfg_we = 1'b0; step = 1'b0;
    check("cfg_over_step_pos", 32'(pos), 32'd5);
    tick();
    check("cfg_over_step_carry", 32'(carry_out), 32'd0);

    // wrap 26 -> 1
    set_cfg(26, 1, 5);
    step = 1'b1;
    tick();
    step = 1'b0;
    check("wrap_pos", 32'(pos), 32'd1);
    check("wrap_carry", 32'(carry_out), 32'd0);

    // duplicate load value
    start_load();
    write_entry(1, 3);
    write_entry(2, 3);
`ifdef ROTOR_PERM_CHECK_EN
    check("dup_err", 32'(err), 32'd1);
    check("dup_ready", 32'(ready), 32'd0);
    write_entry(2, 1);
    write_entry(3, 2);
    for (int i = 4; i <= 25; i++) write_entry(i, i);
    check("dup_cnt_not_ready", 32'(ready), 32'd0);
    write_entry(26, 26);
    check("dup_final_ready", 32'(ready), 32'd1);
`else
    check("dup_err", 32'(err), 32'd0);
    check("dup_ready", 32'(ready), 32'd0);
    for (int i = 3; i <= 25; i++) write_entry(i, i);
    check("dup_cnt_not_ready", 32'(ready), 32'd0);
    write_entry(26, 26);
    check("dup_final_ready", 32'(ready), 32'd1);
    check("dup_final_err", 32'(err), 32'd0);
`endif

    // reset in the middle of a load
    start_load();
    for (int i = 1; i <= 10; i++) write_entry(i, wiring[i-1]);
    set_cfg(7, 1, 5);
    rst_n = 1'b0;
    #2;
    check("midrst_state", 32'(dbg_state), 32'(IDLE));
    check("midrst_pos", 32'(pos), 32'd1);
    check("midrst_ready", 32'(ready), 32'd0);
    tick();
    rst_n = 1'b1;
    tick();
    load_rotor();
    check("reload_ready", 32'(ready), 32'd1);
    translate("reload_fwd", 1'b0, 2, 10);
    translate("reload_inv", 1'b1, 10, 2);
    check("reload_err", 32'(err), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
